boid_frame_scheduler: RTL
=========================

// Module: boid_frame_scheduler
// PURPOSE
//  Sequences the double-buffered 1-bit boid framebuffer (two DEPTH x 1 RAM banks).
//  - Decides which bank is front (read by VGA) and which is back (cleared, then drawn).
//  - Swaps banks only on a vsync rising edge.
//  - Clears the back bank with a linear address sweep.
//  - Gates boid-engine pixel writes with a valid/ready handshake.
//  Sits between the boid update engine and the two RAM banks, replacing free-running reset-sweep logic.
// PARAMETERS
//  DEPTH       1024  pixels per bank
//  ADDR_WIDTH  10    bits of pixel address; DEPTH <= 2**ADDR_WIDTH
// PORTS
//  clk         in   1           system clock
//  reset       in   1           asynchronous, active-high reset
//  vsync       in   1           VGA vsync level, synchronous to clk; rising edge detected internally
//  wr_valid    in   1           boid engine has a pixel to set
//  wr_addr     in   ADDR_WIDTH  pixel address to set
//  wr_ready    out  1           write accepted this cycle when wr_valid & wr_ready
//  draw_done   in   1           engine has issued all pixels for this frame
//  frame_start out  1           1-cycle pulse: back bank clear, drawing may begin
//  front_sel   out  1           bank the VGA reads (0 = bank0, 1 = bank1)
//  bank0_we    out  1           registered write enable, bank0
//  bank1_we    out  1           registered write enable, bank1
//  mem_addr    out  ADDR_WIDTH  registered write address (shared by both banks)
//  mem_data    out  1           registered write data
//  busy        out  1           high in INIT and CLEAR
// BEHAVIOUR
//  - Reset (async) values:
//    - state = INIT, front_sel = 0, sweep counter = 0, vsync edge register = 0.
//    - All outputs = 0, except busy = 1.
//  - States:
//    - INIT: write 0 to both banks at addr 0..DEPTH-1, one address per cycle (DEPTH cycles).
//      After the last address, go to DRAW and pulse frame_start.
//    - CLEAR: same sweep, back bank only (bank selected by ~front_sel).
//      After addr DEPTH-1, go to DRAW and pulse frame_start in the cycle DRAW is entered.
//    - DRAW: wr_ready = 1.
//      - Accepted write: next cycle back-bank we = 1, mem_addr = wr_addr, mem_data = 1.
//      - wr_addr >= DEPTH: still accepted, but no we asserted (dropped).
//      - draw_done = 1: go to WAIT_VSYNC next cycle. A write accepted in that same cycle is still performed.
//    - WAIT_VSYNC: wr_ready = 0. On a vsync rising edge: toggle front_sel and enter CLEAR at addr 0.
//  - wr_ready = 0 in INIT, CLEAR and WAIT_VSYNC. Write latency is 1 cycle, registered.
//  - The front bank is never written outside INIT.
//  - vsync rising edge seen in INIT, CLEAR or DRAW = overrun:
//    - Edge is dropped; no swap. The old front frame is shown again.
//    - The frame completes normally and waits for the next edge.
//  - Sweep counter wraps to 0 after DEPTH-1; it is 0 on every entry to CLEAR.
//  - draw_done is ignored outside DRAW.
//  - Reset mid-sweep or mid-draw restarts INIT; buffer contents are not trusted.
// CONFIGURATION
//  - BOID_FRAME_OVERRUN_CNT_EN defined:
//    - Adds port overrun_cnt out 16.
//    - Increments on each overrun edge and saturates at 16'hFFFF.
//    - Reset value 0.
//  - Undefined: no port, no counter. Overruns are silently dropped.
// STRUCTURE
//  - Shared package boid_fb_pkg:
//    - state typedef/localparams: INIT, CLEAR, DRAW, WAIT_VSYNC.
//    - BANK0/BANK1 constants.
//    - Clear-data constant 1'b0, draw-data constant 1'b1.
//  - One sub-module, fb_clear_sweeper: start in, addr out, we out, last out.
//    Reused by INIT and CLEAR.
//  - FSM, handshake and vsync edge detect stay in this module.
// TESTING (DEPTH=16, ADDR_WIDTH=4)
//  1. Release reset:
//     - 16 cycles with bank0_we = bank1_we = 1 and mem_addr 0..15, mem_data 0.
//     - Then frame_start pulses once and wr_ready = 1.
//  2. In DRAW, wr_valid with wr_addr = 5, front_sel = 0:
//     - Next cycle bank1_we = 1, mem_addr = 5, mem_data = 1.
//     - bank0_we stays 0.
//  3. Raise draw_done, then vsync:
//     - front_sel goes 0 -> 1.
//     - 16 cycles with bank0_we = 1 only (addr 0..15, data 0).
//     - Then frame_start.
//  4. vsync edge during CLEAR:
//     - front_sel unchanged, clear completes.
//     - With macro, overrun_cnt goes 0 -> 1.
//  5. wr_valid with wr_addr = 15 and draw_done in the same DRAW cycle:
//     - The write is performed.
//     - wr_ready = 0 from the next cycle on.
//  6. Assert reset mid-CLEAR at addr 7:
//     - Outputs are 0 and busy = 1 immediately (async), front_sel = 0.
//     - The INIT sweep restarts from addr 0.

Source files
------------

// File: rtl/boid_fb_pkg.sv
// rtl/boid_fb_pkg.sv - shared states, bank ids and data constants for the boid framebuffer scheduler
package boid_fb_pkg;

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_CLEAR      = 2'd1,
        ST_DRAW       = 2'd2,
        ST_WAIT_VSYNC = 2'd3
    } fb_state_t;

    localparam logic BANK0      = 1'b0;
    localparam logic BANK1      = 1'b1;
    localparam logic CLEAR_DATA = 1'b0;
    localparam logic DRAW_DATA  = 1'b1;

    // Returns {bank1_we, bank0_we} for a write aimed at one bank.
    function automatic logic [1:0] bank_mask(input logic sel);
        return (sel == BANK1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fb_clear_sweeper.sv
// rtl/fb_clear_sweeper.sv - linear 0..DEPTH-1 address sweep used by INIT and CLEAR
module fb_clear_sweeper #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  run_q;
    logic                  at_end;

    assign at_end = (cnt_q == ADDR_WIDTH'(DEPTH - 1));

    // Running out of reset so the INIT sweep needs no separate kick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (start_i) begin
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            cnt_q <= at_end ? '0 : cnt_q + 1'b1;
            run_q <= !at_end;
        end
    end

    assign addr_o = cnt_q;
    assign we_o   = run_q;
    assign last_o = run_q && at_end;

endmodule

// File: rtl/boid_frame_scheduler.sv
// rtl/boid_frame_scheduler.sv - double-buffered boid framebuffer bank scheduler
// Optional overrun counter port enabled by BOID_FRAME_OVERRUN_CNT_EN.
module boid_frame_scheduler
    import boid_fb_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_ready,
    input  logic                  draw_done,
    output logic                  frame_start,
    output logic                  front_sel,
    output logic                  bank0_we,
    output logic                  bank1_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_data,
`ifdef BOID_FRAME_OVERRUN_CNT_EN
    output logic [15:0]           overrun_cnt,
`endif
    output logic                  busy
);

    fb_state_t             state_q;
    logic                  vsync_q;
    logic                  front_sel_q;
    logic                  frame_start_q;
    logic [1:0]            we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  data_q;
    logic                  sweep_tail_q;

    logic                  vsync_rise;
    logic                  accept;
    logic                  in_range;
    logic                  sweep_start;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  sweep_we;
    logic                  sweep_last;

    assign vsync_rise  = vsync && !vsync_q;
    assign accept      = wr_valid && (state_q == ST_DRAW);
    assign in_range    = (32'(wr_addr) < DEPTH);
    assign sweep_start = (state_q == ST_WAIT_VSYNC) && vsync_rise;

    fb_clear_sweeper #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweeper (
        .clk     (clk),
        .reset   (reset),
        .start_i (sweep_start),
        .addr_o  (sweep_addr),
        .we_o    (sweep_we),
        .last_o  (sweep_last)
    );

    // sweep_tail_q marks the cycle the final clear write is on the bus, so
    // frame_start follows the whole sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            vsync_q       <= 1'b0;
            front_sel_q   <= BANK0;
            frame_start_q <= 1'b0;
            we_q          <= 2'b00;
            addr_q        <= '0;
            data_q        <= 1'b0;
            sweep_tail_q  <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            frame_start_q <= 1'b0;
            we_q          <= 2'b00;
            sweep_tail_q  <= 1'b0;
            case (state_q)
                ST_INIT, ST_CLEAR: begin
                    if (sweep_we) begin
                        we_q   <= (state_q == ST_INIT) ? 2'b11 : bank_mask(~front_sel_q);
                        addr_q <= sweep_addr;
                        data_q <= CLEAR_DATA;
                    end
                    sweep_tail_q <= sweep_last;
                    if (sweep_tail_q) begin
                        state_q       <= ST_DRAW;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (accept && in_range) begin
                        we_q   <= bank_mask(~front_sel_q);
                        addr_q <= wr_addr;
                        data_q <= DRAW_DATA;
                    end
                    if (draw_done) begin
                        state_q <= ST_WAIT_VSYNC;
                    end
                end
                ST_WAIT_VSYNC: begin
                    if (vsync_rise) begin
                        front_sel_q <= ~front_sel_q;
                        state_q     <= ST_CLEAR;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef BOID_FRAME_OVERRUN_CNT_EN
    logic [15:0] overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 16'h0000;
        end else if (vsync_rise && (state_q != ST_WAIT_VSYNC) && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'h0001;
        end
    end

    assign overrun_cnt = overrun_q;
`endif

    assign wr_ready    = (state_q == ST_DRAW);
    assign busy        = (state_q == ST_INIT) || (state_q == ST_CLEAR);
    assign frame_start = frame_start_q;
    assign front_sel   = front_sel_q;
    assign bank0_we    = we_q[0];
    assign bank1_we    = we_q[1];
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;

endmodule
